// File: rtl/axi_dac_jesd204_pattern_gen.sv
// Per-channel DAC transmit sample source for the JESD204 TX datapath.
// Selects DMA samples, zero, ramp, PN7 or PN15 patterns, applies the DAC
// data format and registers DATA_PATH_WIDTH samples per cycle toward the link.
// A one-cycle underflow pulse marks cycles where DMA was selected but empty.
module axi_dac_jesd204_pattern_gen #(
   parameter int DATA_PATH_WIDTH = 4,
   parameter bit DATAFMT_DISABLE = 1'b0
) (
   input  logic                          dac_clk,
   input  logic                          dac_rst,
   input  logic                          dac_enable,
   input  logic [3:0]                    dac_data_sel,
   input  logic                          dac_dfmt_type,
   input  logic [16*DATA_PATH_WIDTH-1:0] dac_ddata,
   input  logic                          dac_ddata_valid,
   output logic                          dac_dvalid,
   output logic                          dac_dunf,
   output logic [16*DATA_PATH_WIDTH-1:0] dac_data
);

   localparam int DPW = DATA_PATH_WIDTH;
   localparam int NB  = 16 * DPW;

   localparam logic [3:0] SEL_DMA  = 4'd0;
   localparam logic [3:0] SEL_RAMP = 4'd2;
   localparam logic [3:0] SEL_PN7  = 4'd3;
   localparam logic [3:0] SEL_PN15 = 4'd4;

   localparam logic [6:0]  PN7_SEED  = 7'h7F;
   localparam logic [14:0] PN15_SEED = 15'h7FFF;

   // PN7 (x^7+x^6+1) bits for one cycle; the first generated bit lands in
   // the MSB of sample 0, filling each sample MSB-first before the next.
   function automatic logic [NB-1:0] pn7_word(input logic [6:0] seed);
      logic [6:0]    s;
      logic          b;
      logic [NB-1:0] w;
      s = seed;
      w = '0;
      for (int i = 0; i < NB; i++) begin
         b = s[6] ^ s[5];
         s = {s[5:0], b};
         w[16*(i/16) + 15 - (i%16)] = b;
      end
      return w;
   endfunction

   // PN7 state after one cycle worth of steps.
   function automatic logic [6:0] pn7_adv(input logic [6:0] seed);
      logic [6:0] s;
      s = seed;
      for (int i = 0; i < NB; i++) begin
         s = {s[5:0], s[6] ^ s[5]};
      end
      return s;
   endfunction

   // PN15 (x^15+x^14+1) bits for one cycle, same bit ordering as PN7.
   function automatic logic [NB-1:0] pn15_word(input logic [14:0] seed);
      logic [14:0]   s;
      logic          b;
      logic [NB-1:0] w;
      s = seed;
      w = '0;
      for (int i = 0; i < NB; i++) begin
         b = s[14] ^ s[13];
         s = {s[13:0], b};
         w[16*(i/16) + 15 - (i%16)] = b;
      end
      return w;
   endfunction

   // PN15 state after one cycle worth of steps.
   function automatic logic [14:0] pn15_adv(input logic [14:0] seed);
      logic [14:0] s;
      s = seed;
      for (int i = 0; i < NB; i++) begin
         s = {s[13:0], s[14] ^ s[13]};
      end
      return s;
   endfunction

   // Offset binary is two's complement with each sample MSB inverted.
   function automatic logic [NB-1:0] fmt_word(input logic [NB-1:0] raw,
                                              input logic          obin);
      logic [NB-1:0] w;
      w = raw;
      for (int k = 0; k < DPW; k++) begin
         w[16*k + 15] = raw[16*k + 15] ^ obin;
      end
      return w;
   endfunction

   logic [3:0]    r_sel_d;
   logic          r_en_d;
   logic [15:0]   r_ramp_base;
   logic [6:0]    r_pn7;
   logic [14:0]   r_pn15;
   logic [NB-1:0] r_data;
   logic          r_dunf;

   logic          w_restart;
   logic          w_active;
   logic [15:0]   w_ramp_cur;
   logic [6:0]    w_pn7_cur;
   logic [14:0]   w_pn15_cur;
   logic [NB-1:0] w_raw;
   logic          w_unf;
   logic          w_obin;

   // A source change or an enable rising edge restarts the selected
   // generator from its seed in the same cycle it is first used.
   assign w_restart  = (dac_data_sel != r_sel_d) | (dac_enable & ~r_en_d);
   assign w_active   = dac_enable;
   assign w_ramp_cur = w_restart ? 16'h0000  : r_ramp_base;
   assign w_pn7_cur  = w_restart ? PN7_SEED  : r_pn7;
   assign w_pn15_cur = w_restart ? PN15_SEED : r_pn15;
   assign w_obin     = dac_dfmt_type & ~DATAFMT_DISABLE;

   assign dac_dvalid = ~dac_rst & dac_enable & (dac_data_sel == SEL_DMA);
   assign dac_dunf   = r_dunf;
   assign dac_data   = r_data;

   // Pre-format sample mux; an empty DMA cycle sends zero and flags underflow.
   always_comb begin
      w_raw = '0;
      w_unf = 1'b0;
      if (w_active) begin
         case (dac_data_sel)
            SEL_DMA: begin
               if (dac_ddata_valid) begin
                  w_raw = dac_ddata;
               end else begin
                  w_unf = 1'b1;
               end
            end
            SEL_RAMP: begin
               for (int k = 0; k < DPW; k++) begin
                  w_raw[16*k +: 16] = w_ramp_cur + 16'(k);
               end
            end
            SEL_PN7:  w_raw = pn7_word(w_pn7_cur);
            SEL_PN15: w_raw = pn15_word(w_pn15_cur);
            default:  w_raw = '0;
         endcase
      end
   end

   // Output register, underflow pulse and restart-detection history.
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         r_data  <= '0;
         r_dunf  <= 1'b0;
         r_sel_d <= 4'd0;
         r_en_d  <= 1'b0;
      end else begin
         r_data  <= fmt_word(w_raw, w_obin);
         r_dunf  <= w_unf;
         r_sel_d <= dac_data_sel;
         r_en_d  <= dac_enable;
      end
   end

   // Pattern generators advance only while selected and enabled, else hold.
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         r_ramp_base <= 16'h0000;
         r_pn7       <= PN7_SEED;
         r_pn15      <= PN15_SEED;
      end else if (w_active) begin
         if (dac_data_sel == SEL_RAMP) begin
            r_ramp_base <= w_ramp_cur + 16'(DPW);
         end
         if (dac_data_sel == SEL_PN7) begin
            r_pn7 <= pn7_adv(w_pn7_cur);
         end
         if (dac_data_sel == SEL_PN15) begin
            r_pn15 <= pn15_adv(w_pn15_cur);
         end
      end
   end

endmodule

// File: tb/tb_axi_dac_jesd204_pattern_gen.sv
// Bench for axi_dac_jesd204_pattern_gen: random and directed stimulus
// against a reference built from sample counters and precomputed PN tables.
module tb_axi_dac_jesd204_pattern_gen;

   localparam int DPW = 4;
   localparam int NB  = 16 * DPW;

   logic          clk;
   logic          rst;
   logic          en;
   logic [3:0]    sel;
   logic          fmt;
   logic [NB-1:0] ddata;
   logic          dvld_in;
   logic          dvalid;
   logic          dunf;
   logic [NB-1:0] data;

   int total;
   int bad;

   // Reference state: previous sel/enable, ramp value, PN sequence positions.
   logic [3:0] m_sel_prev;
   bit         m_en_prev;
   int         m_ramp;
   int         m_p7;
   int         m_p15;

   bit seq7  [127];
   bit seq15 [32767];

   axi_dac_jesd204_pattern_gen #(
      .DATA_PATH_WIDTH (DPW),
      .DATAFMT_DISABLE (1'b0)
   ) dut (
      .dac_clk         (clk),
      .dac_rst         (rst),
      .dac_enable      (en),
      .dac_data_sel    (sel),
      .dac_dfmt_type   (fmt),
      .dac_ddata       (ddata),
      .dac_ddata_valid (dvld_in),
      .dac_dvalid      (dvalid),
      .dac_dunf        (dunf),
      .dac_data        (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check combinational dvalid, predict, clock, check outputs.
   task automatic step();
      logic [NB-1:0] raw;
      logic [NB-1:0] exp;
      bit            unf;
      bit            restart;
      #1;
      chk("dvalid", NB'(dvalid), NB'(!rst && en && sel == 4'd0));
      raw = '0;
      unf = 1'b0;
      if (rst) begin
         exp        = '0;
         m_sel_prev = 4'd0;
         m_en_prev  = 1'b0;
      end else begin
         restart    = (sel != m_sel_prev) || (en && !m_en_prev);
         m_sel_prev = sel;
         m_en_prev  = en;
         if (en) begin
            case (sel)
               4'd0: begin
                  if (dvld_in) raw = ddata;
                  else         unf = 1'b1;
               end
               4'd2: begin
                  if (restart) m_ramp = 0;
                  for (int k = 0; k < DPW; k++) raw[16*k +: 16] = 16'((m_ramp + k) % 65536);
                  m_ramp = (m_ramp + DPW) % 65536;
               end
               4'd3: begin
                  if (restart) m_p7 = 0;
                  for (int i = 0; i < NB; i++) raw[16*(i/16) + 15 - (i%16)] = seq7[(m_p7 + i) % 127];
                  m_p7 = (m_p7 + NB) % 127;
               end
               4'd4: begin
                  if (restart) m_p15 = 0;
                  for (int i = 0; i < NB; i++) raw[16*(i/16) + 15 - (i%16)] = seq15[(m_p15 + i) % 32767];
                  m_p15 = (m_p15 + NB) % 32767;
               end
               default: raw = '0;
            endcase
         end
         exp = fmt ? (raw ^ {DPW{16'h8000}}) : raw;
      end
      @(posedge clk);
      #1;
      chk("data", data, exp);
      chk("dunf", NB'(dunf), NB'(unf));
   endtask

   task automatic set_in(input bit r, input bit e, input logic [3:0] s, input bit f);
      rst = r;
      en  = e;
      sel = s;
      fmt = f;
   endtask

   initial begin
      logic [6:0]  s7;
      logic [14:0] s15;
      bit          b;
      int          run;

      total = 0;
      bad   = 0;
      m_sel_prev = 4'd0;
      m_en_prev  = 1'b0;
      m_ramp = 0;
      m_p7   = 0;
      m_p15  = 0;

      s7 = 7'h7F;
      for (int i = 0; i < 127; i++) begin
         b = s7[6] ^ s7[5];
         seq7[i] = b;
         s7 = {s7[5:0], b};
      end
      s15 = 15'h7FFF;
      for (int i = 0; i < 32767; i++) begin
         b = s15[14] ^ s15[13];
         seq15[i] = b;
         s15 = {s15[13:0], b};
      end

      ddata   = '0;
      dvld_in = 1'b0;
      set_in(1'b1, 1'b1, 4'd2, 1'b1);
      @(posedge clk);
      #1;

      // Reset with arbitrary inputs.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'($urandom), 4'($urandom_range(0, 4)), 1'($urandom));
         ddata   = {$urandom, $urandom};
         dvld_in = 1'($urandom);
         step();
      end
      chk("rst_data", data, '0);

      // Ramp from zero, then run up to the wrap point.
      set_in(1'b0, 1'b1, 4'd2, 1'b0);
      step();
      chk("ramp_first", data, 64'h0003_0002_0001_0000);
      step();
      chk("ramp_second", data, 64'h0007_0006_0005_0004);
      for (int i = 0; i < 16382; i++) step();
      chk("ramp_top", data, 64'hFFFF_FFFE_FFFD_FFFC);
      step();
      chk("ramp_wrap", data, 64'h0003_0002_0001_0000);

      // PN7 then PN15, 1000 cycles each.
      set_in(1'b0, 1'b1, 4'd3, 1'b0);
      for (int i = 0; i < 1000; i++) step();
      set_in(1'b0, 1'b1, 4'd4, 1'b0);
      for (int i = 0; i < 1000; i++) step();

      // DMA with toggling valid and random data/format.
      set_in(1'b0, 1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         fmt     = 1'($urandom);
         ddata   = {$urandom, $urandom};
         dvld_in = (i % 3 != 2) ? 1'($urandom) : 1'b0;
         step();
      end

      // Offset binary: zero source and full-scale DMA sample.
      set_in(1'b0, 1'b1, 4'd1, 1'b1);
      step();
      chk("fmt_zero", data, {DPW{16'h8000}});
      set_in(1'b0, 1'b1, 4'd0, 1'b1);
      ddata   = {DPW{16'h7FFF}};
      dvld_in = 1'b1;
      step();
      chk("fmt_max", data, {DPW{16'hFFFF}});

      // Restart: PN15 -> ramp -> PN15, and enable toggles.
      set_in(1'b0, 1'b1, 4'd4, 1'b0);
      for (int i = 0; i < 50; i++) step();
      set_in(1'b0, 1'b1, 4'd2, 1'b0);
      step();
      chk("restart_ramp", data, 64'h0003_0002_0001_0000);
      for (int i = 0; i < 9; i++) step();
      set_in(1'b0, 1'b1, 4'd4, 1'b0);
      for (int i = 0; i < 10; i++) step();
      set_in(1'b0, 1'b0, 4'd4, 1'b0);
      for (int i = 0; i < 3; i++) step();
      set_in(1'b0, 1'b1, 4'd4, 1'b0);
      for (int i = 0; i < 10; i++) step();
      set_in(1'b0, 1'b0, 4'd2, 1'b0);
      step();
      set_in(1'b0, 1'b1, 4'd2, 1'b0);
      step();
      chk("restart_en", data, 64'h0003_0002_0001_0000);

      // Random mix including mid-pattern resets and undefined selects.
      for (int n = 0; n < 300; n++) begin
         set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0),
                4'($urandom_range(0, 7) == 0 ? $urandom_range(5, 15) : $urandom_range(0, 4)),
                1'($urandom));
         run = $urandom_range(1, 12);
         for (int i = 0; i < run; i++) begin
            ddata   = {$urandom, $urandom};
            dvld_in = ($urandom_range(0, 3) != 0);
            step();
            if (rst) rst = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
